// File: rtl/dvp_capture_multi.sv
// dvp_capture_multi: DVP byte-stream capture with frame skipping and 1/2/3-byte pixel assembly.
// Define DVP_CAP_TESTPAT_EN to replace pix_data with an 8-bar colour pattern.
module dvp_capture_multi #(
    parameter int DVP_W      = 8,
    parameter int WAIT_FRAME = 10,
    parameter bit VSYNC_POL  = 1'b1,
    parameter int H_ACT      = 0,
    parameter int X_W        = 12,
    parameter int Y_W        = 12
) (
    input  logic             cam_pclk,
    input  logic             rst,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [DVP_W-1:0] cam_data,
    input  logic [1:0]       fmt,
    output logic             cam_rst_n,
    output logic             cam_pwdn,
    output logic             locked,
    output logic             frame_start,
    output logic             line_end,
    output logic             pix_valid,
    output logic [23:0]      pix_data,
    output logic [X_W-1:0]   x_cnt,
    output logic [Y_W-1:0]   y_cnt,
    output logic [15:0]      frame_cnt,
    output logic             err
);
    typedef enum logic {SKIP, RUN} state_t;
    state_t state, state_nx;
    logic s1_v, s1_h, s2_v, s2_h;
    logic [7:0] s1_d, b0, b1, skip_cnt;
    logic [1:0] fmt_q, phase, last_ph;
    logic fs, href_rise, href_fall, run, enter, byte_en, complete, done, y_inc, line_ok;
    logic [23:0] asm_pix, asm_nx, pix_nx;
    logic [X_W:0] line_px;
    logic [2:0] bar;

    assign cam_rst_n = 1'b1;
    assign cam_pwdn  = 1'b0;
    assign fs        = (s1_v == VSYNC_POL) && (s2_v != VSYNC_POL);
    assign href_rise = s1_h & ~s2_h;
    assign href_fall = ~s1_h & s2_h;
    assign run       = state == RUN;
    // the frame start that leaves SKIP is itself a captured frame
    assign enter     = fs && (run || skip_cnt == 8'(WAIT_FRAME));
    assign line_ok   = run && href_fall && line_px != '0;

    always_ff @(posedge cam_pclk or posedge rst)
        if (rst) state <= SKIP;
        else state <= state_nx;

    always_comb state_nx = (state == SKIP && enter) ? RUN : state;

    always_comb locked = state == RUN;

    always_comb begin
        last_ph  = fmt_q == 2'd1 ? 2'd2 : fmt_q == 2'd2 ? 2'd0 : 2'd1;
        byte_en  = run && s1_h;
        complete = byte_en && phase == last_ph;
        asm_nx   = fmt_q == 2'd0 ? {b0[7:3], 3'b0, b0[2:0], s1_d[7:5], 2'b0, s1_d[4:0], 3'b0} :
                   fmt_q == 2'd1 ? {b0, b1, s1_d} :
                   fmt_q == 2'd2 ? {3{s1_d}} : {3{b0}};
        bar      = x_cnt[X_W-1 -: 3];
`ifdef DVP_CAP_TESTPAT_EN
        pix_nx   = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
`else
        pix_nx   = asm_pix;
`endif
    end

    always_ff @(posedge cam_pclk or posedge rst)
        if (rst) begin
            s1_v        <= 1'b0;
            s1_h        <= 1'b0;
            s1_d        <= '0;
            s2_v        <= 1'b0;
            s2_h        <= 1'b0;
            skip_cnt    <= '0;
            fmt_q       <= '0;
            phase       <= '0;
            b0          <= '0;
            b1          <= '0;
            done        <= 1'b0;
            asm_pix     <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_px     <= '0;
            line_end    <= 1'b0;
            err         <= 1'b0;
            y_inc       <= 1'b0;
        end else begin
            s1_v        <= cam_vsync;
            s1_h        <= cam_href;
            s1_d        <= cam_data[7:0];
            s2_v        <= s1_v;
            s2_h        <= s1_h;
            if (fs && !run) skip_cnt <= skip_cnt + 1'b1;
            frame_start <= enter;
            if (enter) begin
                fmt_q     <= fmt;
                frame_cnt <= frame_cnt + 16'd1;
            end
            phase       <= (!byte_en || complete) ? 2'd0 : phase + 2'd1;
            if (byte_en && phase == 2'd0) b0 <= s1_d;
            if (byte_en && phase == 2'd1) b1 <= s1_d;
            done        <= complete;
            if (complete) asm_pix <= asm_nx;
            pix_valid   <= done;
            if (done) pix_data <= pix_nx;
            x_cnt       <= href_rise ? '0 : pix_valid ? x_cnt + 1'b1 : x_cnt;
            line_px     <= href_rise ? {{X_W{1'b0}}, complete} : line_px + {{X_W{1'b0}}, complete};
            // a trailing partial pixel is dropped and flagged via phase
            line_end    <= line_ok;
            err         <= line_ok && (phase != 2'd0 || (H_ACT != 0 && line_px != (X_W+1)'(H_ACT)));
            y_inc       <= line_ok && !enter;
            y_cnt       <= enter ? '0 : y_inc ? y_cnt + 1'b1 : y_cnt;
        end
endmodule

// File: tb/tb_dvp_capture_multi.sv
// tb_dvp_capture_multi: directed-vector bench for dvp_capture_multi (WAIT_FRAME=2, H_ACT=2).
module tb_dvp_capture_multi;
    logic clk = 1'b0, rst = 1'b1, vsync = 1'b0, href = 1'b0;
    logic [7:0] data = '0;
    logic [1:0] fmt = '0;
    logic cam_rst_n, cam_pwdn, locked, frame_start, line_end, pix_valid, err;
    logic [23:0] pix_data;
    logic [11:0] x_cnt, y_cnt;
    logic [15:0] frame_cnt;

    dvp_capture_multi #(.DVP_W(8), .WAIT_FRAME(2), .VSYNC_POL(1'b1), .H_ACT(2), .X_W(12), .Y_W(12)) dut (
        .cam_pclk(clk), .rst(rst), .cam_vsync(vsync), .cam_href(href), .cam_data(data), .fmt(fmt),
        .cam_rst_n(cam_rst_n), .cam_pwdn(cam_pwdn), .locked(locked), .frame_start(frame_start),
        .line_end(line_end), .pix_valid(pix_valid), .pix_data(pix_data), .x_cnt(x_cnt),
        .y_cnt(y_cnt), .frame_cnt(frame_cnt), .err(err));

    always #5 clk = ~clk;

    int cyc = 0, fs_n = 0, n_vec = 0, n_bad = 0;
    logic [23:0] pv_d[$];
    int pv_x[$], pv_c[$], le_y[$], bc[$];
    logic le_e[$];
    logic [7:0] bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pix_valid) begin
            pv_d.push_back(pix_data);
            pv_x.push_back(int'(x_cnt));
            pv_c.push_back(cyc);
        end
        if (line_end) begin
            le_y.push_back(int'(y_cnt));
            le_e.push_back(err);
        end
        if (frame_start) fs_n++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse();
        vsync = 1'b1;
        idle(3);
        vsync = 1'b0;
        idle(4);
    endtask

    task automatic send_line();
        pv_d.delete(); pv_x.delete(); pv_c.delete(); le_y.delete(); le_e.delete(); bc.delete();
        foreach (bytes[i]) begin
            href = 1'b1;
            data = bytes[i];
            bc.push_back(cyc + 1);
            @(negedge clk);
        end
        href = 1'b0;
        idle(8);
    endtask

    task automatic check_pix(input string tag, input int i, input logic [23:0] exp, input int n);
        check({tag, "_data"}, i < pv_d.size() ? pv_d[i] : 24'hx, exp);
        check({tag, "_x"}, i < pv_x.size() ? pv_x[i] : -1, i);
        if (i < pv_c.size() && (i + 1) * n - 1 < bc.size())
            check({tag, "_lat"}, pv_c[i] - bc[(i + 1) * n - 1], 2);
        else
            check({tag, "_lat"}, 32'hFFFF_FFFF, 2);
    endtask

    task automatic check_line(input string tag, input logic exp_err, input int exp_y);
        check({tag, "_le_n"}, le_e.size(), 1);
        check({tag, "_err"}, le_e.size() > 0 ? le_e[0] : 1'bx, exp_err);
        check({tag, "_le_y"}, le_y.size() > 0 ? le_y[0] : -1, exp_y);
        check({tag, "_y_after"}, y_cnt, exp_y + 1);
    endtask

    initial begin
        idle(3);
        check("rst_flags", {locked, pix_valid, line_end, frame_start, err, cam_rst_n, cam_pwdn}, 7'b0000010);
        check("rst_cnts", {frame_cnt, x_cnt, y_cnt}, 0);
        check("rst_pix", pix_data, 0);
        rst = 1'b0;
        idle(2);

        fmt = 2'd0;
        bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        vs_pulse(); send_line();
        check("skip1_pv", pv_d.size(), 0);
        vs_pulse(); send_line();
        check("skip2_pv", pv_d.size(), 0);
        check("skip_locked", locked, 0);
        check("skip_fs", fs_n, 0);
        vs_pulse();
        check("run_locked", locked, 1);
        check("run_fs", fs_n, 1);
        check("run_fcnt", frame_cnt, 1);
        send_line();
        check("565_n", pv_d.size(), 2);
        check_pix("565_p0", 0, 24'hF80000, 2);
        check_pix("565_p1", 1, 24'h00FC00, 2);
        check_line("565", 1'b0, 0);

        fmt = 2'd1;
        vs_pulse();
        check("f4_fs", fs_n, 2);
        check("f4_fcnt", frame_cnt, 2);
        check("f4_y0", y_cnt, 0);
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_line();
        check("888_n", pv_d.size(), 2);
        check_pix("888_p0", 0, 24'h010203, 3);
        check_pix("888_p1", 1, 24'h040506, 3);
        check_line("888", 1'b0, 0);

        bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send_line();
        check("part_n", pv_d.size(), 2);
        check_pix("part_p0", 0, 24'h111213, 3);
        check_pix("part_p1", 1, 24'h141516, 3);
        check_line("part", 1'b1, 1);

        fmt = 2'd2;
        bytes = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        send_line();
        check("midfmt_n", pv_d.size(), 2);
        check_pix("midfmt_p0", 0, 24'h212223, 3);
        check_pix("midfmt_p1", 1, 24'h242526, 3);

        vs_pulse();
        bytes = '{8'h5A, 8'hA5};
        send_line();
        check("raw_n", pv_d.size(), 2);
        check_pix("raw_p0", 0, 24'h5A5A5A, 1);
        check_pix("raw_p1", 1, 24'hA5A5A5, 1);
        check_line("raw", 1'b0, 0);

        fmt = 2'd3;
        vs_pulse();
        bytes = '{8'h80, 8'h11, 8'h90, 8'h22};
        send_line();
        check("yuv_n", pv_d.size(), 2);
        check_pix("yuv_p0", 0, 24'h808080, 2);
        check_pix("yuv_p1", 1, 24'h909090, 2);
        check_line("yuv", 1'b0, 0);
        check("yuv_fcnt", frame_cnt, 4);

        href = 1'b1;
        data = 8'h33;
        idle(3);
        rst = 1'b1;
        #1;
        check("mrst_flags", {locked, pix_valid, line_end, frame_start, err}, 5'b0);
        check("mrst_cnts", {frame_cnt, x_cnt, y_cnt}, 0);
        check("mrst_pix", pix_data, 0);
        @(negedge clk);
        rst = 1'b0;
        href = 1'b0;
        idle(3);

        fmt = 2'd1;
        bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        vs_pulse(); send_line();
        check("reskip1_pv", pv_d.size(), 0);
        vs_pulse(); send_line();
        check("reskip2_pv", pv_d.size(), 0);
        check("reskip_locked", locked, 0);
        vs_pulse();
        check("relock", locked, 1);
        check("relock_fcnt", frame_cnt, 1);
        send_line();
        check("relock_n", pv_d.size(), 2);
        check_pix("relock_p0", 0, 24'h010203, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
